reg_writeback_queue: RTL and testbench

//   Buffered write-back front end for the 32x32 register file write port
//   (regwrite / write_reg / write_data). Accepts result packets (rd, data)

---
 rtl/reg_writeback_queue_if.sv | 21 ++
 rtl/reg_writeback_queue.sv | 98 +++++++++
 tb/tb_reg_writeback_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Producer-side result handshake into the write-back queue.
interface reg_writeback_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;

    modport master (
        output in_valid,
        output in_rd,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rd,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue in front of the register file write port, with
// youngest-match forwarding of results that have not yet retired.
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_writeback_queue_if.slave  in_if,
    input  logic                  wb_enable,
    output logic                  regwrite,
    output logic [4:0]            write_reg,
    output logic [31:0]           write_data,
    input  logic [4:0]            read_reg_1,
    input  logic [4:0]            read_reg_2,
    output logic                  fwd_hit1,
    output logic [31:0]           fwd_data1,
    output logic                  fwd_hit2,
    output logic [31:0]           fwd_data2,
    output logic [AW:0]           count
);

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          push;
    logic          pop;

    assign full         = (count == (AW+1)'(DEPTH));
    assign in_if.in_ready = !full;

    // x0 writes complete the handshake but are never stored.
    assign push = in_if.in_valid && !full && (in_if.in_rd != 5'd0);
    assign pop  = wb_enable && (count != '0);

    assign regwrite   = pop;
    assign write_reg  = pop ? rd_q[rd_ptr]   : '0;
    assign write_data = pop ? data_q[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            rd_q[wr_ptr]   <= in_if.in_rd;
            data_q[wr_ptr] <= in_if.in_data;
        end
    end

    logic [1:0][4:0]  lookup_addr;
    logic [1:0]       lookup_hit;
    logic [1:0][31:0] lookup_data;

    assign lookup_addr = {read_reg_2, read_reg_1};

    // Scan oldest to youngest so the last match seen is the youngest value.
    always_comb begin
        logic [AW-1:0] idx;
        idx         = '0;
        lookup_hit  = '0;
        lookup_data = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + AW'(i);
                if (((AW+1)'(i) < count) && (lookup_addr[p] != 5'd0) &&
                    (rd_q[idx] == lookup_addr[p])) begin
                    lookup_hit[p]  = 1'b1;
                    lookup_data[p] = data_q[idx];
                end
            end
        end
    end

    assign fwd_hit1  = lookup_hit[0];
    assign fwd_data1 = lookup_data[0];
    assign fwd_hit2  = lookup_hit[1];
    assign fwd_data2 = lookup_data[1];

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: stimulus queues expected writes,
// a negedge monitor retires them against the register file write port.
module tb_reg_writeback_queue;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_enable;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic [2:0]  count;

    int  vectors    = 0;
    int  miscompares = 0;
    bit  mon_on     = 1'b0;
    wb_t sb[$];
    wb_t mon_exp;

    reg_writeback_queue_if bus ();

    reg_writeback_queue #(.DEPTH(4), .AW(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_if      (bus),
        .wb_enable  (wb_enable),
        .regwrite   (regwrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg_1 (read_reg_1),
        .read_reg_2 (read_reg_2),
        .fwd_hit1   (fwd_hit1),
        .fwd_data1  (fwd_data1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data2  (fwd_data2),
        .count      (count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    // Monitor: every negedge, the write port must match the scoreboard head.
    always @(negedge clock) begin
        if (mon_on) begin
            vectors++;
            if (regwrite === 1'b1) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL wb_unexpected: write rd=%0d data=%0h, required no write",
                             write_reg, write_data);
                end else begin
                    mon_exp = sb.pop_front();
                    if (write_reg !== mon_exp.rd || write_data !== mon_exp.data) begin
                        miscompares++;
                        $display("FAIL wb_write: got rd=%0d data=%0h, required rd=%0d data=%0h",
                                 write_reg, write_data, mon_exp.rd, mon_exp.data);
                    end
                end
            end else if (regwrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
                miscompares++;
                $display("FAIL wb_idle: got regwrite=%b rd=%0d data=%0h, required 0/0/0",
                         regwrite, write_reg, write_data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] rd, input logic [31:0] data);
        bit took;
        took = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_rd    = rd;
        bus.in_data  = data;
        if (rd != 5'd0) sb.push_back({rd, data});
        for (int c = 0; c < 40 && !took; c++) begin
            @(negedge clock);
            took = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!took) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: rd=%0d never accepted, required acceptance", rd);
        end
    endtask

    task automatic wait_empty(input string name);
        int c;
        c = 0;
        while ((count != 3'd0 || sb.size() != 0) && c < 50) begin
            tick();
            c++;
        end
        check(name, {29'd0, count}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        wb_enable    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd7;
        bus.in_data  = 32'h55;
        read_reg_1   = 5'd0;
        read_reg_2   = 5'd0;

        // Reset held two cycles with a valid packet presented
        tick();
        mon_on = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_regwrite", {31'd0, regwrite}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_fwd_hit", {30'd0, fwd_hit2, fwd_hit1}, 32'd0);
        repeat (2) tick();

        // Single push, written the following edge
        send(5'd1, 32'd30);
        check("single_count", {29'd0, count}, 32'd1);
        check("single_regwrite", {31'd0, regwrite}, 32'd1);
        check("single_write_reg", {27'd0, write_reg}, 32'd1);
        check("single_write_data", write_data, 32'd30);
        tick();
        check("single_after_regwrite", {31'd0, regwrite}, 32'd0);
        check("single_after_count", {29'd0, count}, 32'd0);

        // x0 packets are accepted and dropped
        send(5'd0, 32'hDEAD);
        check("x0_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("x0_count", {29'd0, count}, 32'd0);
        repeat (2) tick();

        // Fill with retirement stalled, fifth held until space opens
        wb_enable = 1'b0;
        for (int i = 1; i <= 4; i++) send(5'(i), 32'(100 + i));
        check("full_count", {29'd0, count}, 32'd4);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd5;
        bus.in_data  = 32'd105;
        tick();
        tick();
        check("full_held_count", {29'd0, count}, 32'd4);
        check("full_held_regwrite", {31'd0, regwrite}, 32'd0);
        wb_enable = 1'b1;
        send(5'd5, 32'd105);
        wait_empty("full_drain");

        // Forwarding: youngest match wins, x0 and incoming packet never hit
        wb_enable = 1'b0;
        send(5'd3, 32'd10);
        send(5'd3, 32'd20);
        send(5'd4, 32'd7);
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd4;
        #1;
        check("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
        check("fwd_data1_youngest", fwd_data1, 32'd20);
        check("fwd_hit2", {31'd0, fwd_hit2}, 32'd1);
        check("fwd_data2", fwd_data2, 32'd7);
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd9;
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd9;
        bus.in_data  = 32'd99;
        #1;
        check("fwd_x0_hit", {31'd0, fwd_hit1}, 32'd0);
        check("fwd_x0_data", fwd_data1, 32'd0);
        check("fwd_incoming_hit", {31'd0, fwd_hit2}, 32'd0);
        check("fwd_incoming_data", fwd_data2, 32'd0);
        bus.in_valid = 1'b0;
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd0;
        wb_enable  = 1'b1;
        tick();
        check("fwd_after_pop_hit", {31'd0, fwd_hit1}, 32'd1);
        check("fwd_after_pop_data", fwd_data1, 32'd20);
        wait_empty("fwd_drain");
        check("fwd_empty_hit", {31'd0, fwd_hit1}, 32'd0);

        // Streaming push and retire every cycle across pointer wrap
        wb_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            send(5'(i), 32'(i * 3));
            check("stream_count_le1", {31'd0, count <= 3'd1}, 32'd1);
        end
        wait_empty("stream_drain");

        // Reset with entries pending discards them
        wb_enable = 1'b0;
        send(5'd20, 32'd1);
        send(5'd21, 32'd2);
        check("pre_reset_count", {29'd0, count}, 32'd2);
        reset = 1'b1;
        tick();
        sb.delete();
        reset = 1'b0;
        check("mid_reset_count", {29'd0, count}, 32'd0);
        check("mid_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        wb_enable = 1'b1;
        repeat (3) tick();
        check("mid_reset_regwrite", {31'd0, regwrite}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
